// File: rtl/nand_read_sequencer_if.sv
// Host port of nand_master: opcode/data strobe out, busy/data back.
interface nand_read_sequencer_if;
  logic [5:0] nm_cmd;
  logic [7:0] nm_data_in;
  logic       nm_activate;
  logic       nm_busy;
  logic [7:0] nm_data_out;

  modport master (output nm_cmd, nm_data_in, nm_activate, input nm_busy, nm_data_out);
  modport slave  (input nm_cmd, nm_data_in, nm_activate, output nm_busy, nm_data_out);
endinterface

// File: rtl/nand_read_sequencer.sv
// Sequences nand_master opcodes for power-up init (reset, CE, NAND reset, READ ID)
// and page reads, streaming page bytes out one at a time on a valid/ready port.
module nand_read_sequencer #(
  parameter int         ADDR_BYTES  = 5,
  parameter int         PAGE_BYTES  = 8640,
  parameter int         ID_BYTES    = 5,
  parameter logic [7:0] CE_SEL      = 8'h00,
  parameter logic [5:0] OP_SET_ADDR = 6'h18,
  parameter int         TIMEOUT_CYC = 2**20
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    init_req,
  input  logic                    rd_req,
  input  logic [8*ADDR_BYTES-1:0] rd_addr,
  output logic                    ready,
  output logic [8*ID_BYTES-1:0]   id_bytes,
  output logic [7:0]              rd_data,
  output logic                    rd_valid,
  input  logic                    rd_ready,
  output logic                    done,
  output logic [7:0]              status,
  output logic                    err,
  nand_read_sequencer_if.master   nm
);
  localparam int IDX_MAX = (ADDR_BYTES > ID_BYTES) ? ADDR_BYTES : ID_BYTES;
  localparam int IDX_W   = $clog2(IDX_MAX + 1);
  localparam int BC_W    = $clog2(PAGE_BYTES + 1);
  localparam int WD_W    = $clog2(TIMEOUT_CYC + 1);

  localparam logic [5:0] OP_RESET      = 6'h01;
  localparam logic [5:0] OP_NAND_RESET = 6'h04;
  localparam logic [5:0] OP_READ_ID    = 6'h06;
  localparam logic [5:0] OP_NAND_READ  = 6'h09;
  localparam logic [5:0] OP_GET_STATUS = 6'h0D;
  localparam logic [5:0] OP_CHIP_EN    = 6'h0E;
  localparam logic [5:0] OP_RESET_IDX  = 6'h12;
  localparam logic [5:0] OP_GET_ID     = 6'h13;
  localparam logic [5:0] OP_GET_DATA   = 6'h15;

  localparam logic [IDX_W-1:0] ID_LAST   = IDX_W'(ID_BYTES - 1);
  localparam logic [IDX_W-1:0] ADDR_LAST = IDX_W'(ADDR_BYTES - 1);
  localparam logic [BC_W-1:0]  PAGE_LAST = BC_W'(PAGE_BYTES - 1);
  localparam logic [WD_W-1:0]  WD_LAST   = WD_W'(TIMEOUT_CYC - 1);
  localparam logic [WD_W-1:0]  HOLDOFF   = WD_W'(2);

  typedef enum logic [2:0] {
    S_INIT_START, S_IDLE, S_ISSUE, S_PULSE, S_WAIT, S_STREAM, S_ERR_HALT
  } state_t;

  typedef enum logic [3:0] {
    ST_RST, ST_CE, ST_NRST, ST_RDID, ST_GETID,
    ST_RIDX0, ST_ADDR, ST_READ, ST_RIDX1, ST_GETDATA, ST_STATUS
  } step_t;

  state_t state, state_d;
  step_t  step, step_d;

  logic [IDX_W-1:0]        idx, idx_d;
  logic [BC_W-1:0]         bcnt, bcnt_d;
  logic [WD_W-1:0]         wd_cnt, wd_d;
  logic [5:0]              cmd_q, cmd_d, step_cmd;
  logic [7:0]              din_q, din_d, step_din;
  logic [8*ADDR_BYTES-1:0] addr_q, addr_d;
  logic [8*ID_BYTES-1:0]   id_d;
  logic [7:0]              rdat_d, stat_d;
  logic                    rvld_d, err_d, done_d, init_ok, ok_d;

  assign ready          = (state == S_IDLE);
  assign nm.nm_activate = (state == S_PULSE);
  assign nm.nm_cmd      = cmd_q;
  assign nm.nm_data_in  = din_q;

  // Opcode and operand for the current step of the sequence.
  always_comb begin
    step_cmd = OP_RESET;
    step_din = 8'h00;
    case (step)
      ST_RST:     step_cmd = OP_RESET;
      ST_CE:      begin step_cmd = OP_CHIP_EN; step_din = CE_SEL; end
      ST_NRST:    step_cmd = OP_NAND_RESET;
      ST_RDID:    step_cmd = OP_READ_ID;
      ST_GETID:   step_cmd = OP_GET_ID;
      ST_RIDX0,
      ST_RIDX1:   step_cmd = OP_RESET_IDX;
      ST_ADDR:    begin step_cmd = OP_SET_ADDR; step_din = addr_q[idx*8 +: 8]; end
      ST_READ:    step_cmd = OP_NAND_READ;
      ST_GETDATA: step_cmd = OP_GET_DATA;
      ST_STATUS:  step_cmd = OP_GET_STATUS;
      default:    step_cmd = OP_RESET;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_INIT_START;
      step  <= ST_RST;
    end else begin
      state <= state_d;
      step  <= step_d;
    end
  end

  always_comb begin
    state_d = state;
    step_d  = step;
    idx_d   = idx;
    bcnt_d  = bcnt;
    wd_d    = wd_cnt;
    cmd_d   = cmd_q;
    din_d   = din_q;
    addr_d  = addr_q;
    id_d    = id_bytes;
    rdat_d  = rd_data;
    rvld_d  = rd_valid;
    stat_d  = status;
    err_d   = err;
    ok_d    = init_ok;
    done_d  = 1'b0;
    case (state)
      S_INIT_START: begin
        step_d  = ST_RST;
        idx_d   = '0;
        ok_d    = 1'b0;
        state_d = S_ISSUE;
      end
      S_IDLE: begin
        if (init_req) begin
          err_d   = 1'b0;
          state_d = S_INIT_START;
        end else if (rd_req) begin
          addr_d  = rd_addr;
          step_d  = ST_RIDX0;
          idx_d   = '0;
          state_d = S_ISSUE;
        end
      end
      S_ERR_HALT: begin
        if (init_req) begin
          err_d   = 1'b0;
          state_d = S_INIT_START;
        end
      end
      S_ISSUE: begin
        if (!nm.nm_busy) begin
          cmd_d   = step_cmd;
          din_d   = step_din;
          state_d = S_PULSE;
        end
      end
      S_PULSE: begin
        wd_d    = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        // Busy may lag activate, so the first two WAIT cycles never complete.
        if (wd_cnt >= HOLDOFF && !nm.nm_busy) begin
          state_d = S_ISSUE;
          case (step)
            ST_RST:   step_d = ST_CE;
            ST_CE:    step_d = ST_NRST;
            ST_NRST:  step_d = ST_RDID;
            ST_RDID:  begin step_d = ST_GETID; idx_d = '0; end
            ST_GETID: begin
              id_d[idx*8 +: 8] = nm.nm_data_out;
              if (idx == ID_LAST) begin
                ok_d    = 1'b1;
                done_d  = 1'b1;
                state_d = S_IDLE;
              end else begin
                idx_d = idx + 1'b1;
              end
            end
            ST_RIDX0: begin step_d = ST_ADDR; idx_d = '0; end
            ST_ADDR: begin
              if (idx == ADDR_LAST) step_d = ST_READ;
              else                  idx_d  = idx + 1'b1;
            end
            ST_READ:  step_d = ST_RIDX1;
            ST_RIDX1: begin step_d = ST_GETDATA; bcnt_d = '0; end
            ST_GETDATA: begin
              rdat_d  = nm.nm_data_out;
              rvld_d  = 1'b1;
              state_d = S_STREAM;
            end
            ST_STATUS: begin
              stat_d  = nm.nm_data_out;
              done_d  = 1'b1;
              state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
          endcase
        end else if (wd_cnt == WD_LAST) begin
          err_d   = 1'b1;
          done_d  = 1'b1;
          state_d = init_ok ? S_IDLE : S_ERR_HALT;
        end else begin
          wd_d = wd_cnt + 1'b1;
        end
      end
      S_STREAM: begin
        // Next GET waits for the consumer so only one byte is ever in flight.
        if (rd_ready) begin
          rvld_d  = 1'b0;
          state_d = S_ISSUE;
          if (bcnt == PAGE_LAST) step_d = ST_STATUS;
          else                   bcnt_d = bcnt + 1'b1;
        end
      end
      default: state_d = S_INIT_START;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idx      <= '0;
      bcnt     <= '0;
      wd_cnt   <= '0;
      cmd_q    <= '0;
      din_q    <= '0;
      addr_q   <= '0;
      id_bytes <= '0;
      rd_data  <= '0;
      rd_valid <= 1'b0;
      status   <= '0;
      err      <= 1'b0;
      done     <= 1'b0;
      init_ok  <= 1'b0;
    end else begin
      idx      <= idx_d;
      bcnt     <= bcnt_d;
      wd_cnt   <= wd_d;
      cmd_q    <= cmd_d;
      din_q    <= din_d;
      addr_q   <= addr_d;
      id_bytes <= id_d;
      rd_data  <= rdat_d;
      rd_valid <= rvld_d;
      status   <= stat_d;
      err      <= err_d;
      done     <= done_d;
      init_ok  <= ok_d;
    end
  end
endmodule

// File: tb/tb_nand_read_sequencer.sv
// Directed bench: behavioural nand_master model, opcode log, stream and watchdog checks.
module tb_nand_read_sequencer;
  localparam int AB = 5, PB = 16, IB = 5, TO = 64;

  logic          clk = 1'b0, reset = 1'b1, init_req = 1'b0, rd_req = 1'b0, rd_ready = 1'b0;
  logic [8*AB-1:0] rd_addr = '0;
  logic          ready, rd_valid, done, err;
  logic [8*IB-1:0] id_bytes;
  logic [7:0]    rd_data, status;

  int checks = 0, errors = 0;
  int n, cnt, stall_err, nf;
  logic [7:0]  got_q [$];
  logic [13:0] log_q [$];

  nand_read_sequencer_if nif();

  nand_read_sequencer #(.ADDR_BYTES(AB), .PAGE_BYTES(PB), .ID_BYTES(IB), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .reset(reset), .init_req(init_req), .rd_req(rd_req), .rd_addr(rd_addr),
    .ready(ready), .id_bytes(id_bytes), .rd_data(rd_data), .rd_valid(rd_valid),
    .rd_ready(rd_ready), .done(done), .status(status), .err(err), .nm(nif.master));

  always #5 clk = ~clk;

  // nand_master model: busy 3 cycles per command, ID 2C E5 FF 03 86, page 40,41,..
  logic [39:0] id_word = 40'h86_03_FF_E5_2C;
  int  id_idx, pg_idx, bcnt;
  bit  hang_read = 1'b0, hold;
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      nif.nm_busy <= 1'b0; nif.nm_data_out <= 8'h00;
      id_idx <= 0; pg_idx <= 0; bcnt <= 0; hold <= 1'b0;
    end else if (nif.nm_activate) begin
      log_q.push_back({nif.nm_cmd, nif.nm_data_in});
      nif.nm_busy <= 1'b1; bcnt <= 3;
      hold <= hang_read && (nif.nm_cmd == 6'h09);
      case (nif.nm_cmd)
        6'h06: id_idx <= 0;
        6'h12: pg_idx <= 0;
        6'h13: begin nif.nm_data_out <= id_word[id_idx*8 +: 8]; id_idx <= id_idx + 1; end
        6'h15: begin nif.nm_data_out <= 8'h40 + pg_idx[7:0]; pg_idx <= pg_idx + 1; end
        6'h0D: nif.nm_data_out <= 8'hE0;
        default: ;
      endcase
    end else if (nif.nm_busy && !(hold && hang_read)) begin
      if (bcnt <= 1) nif.nm_busy <= 1'b0;
      bcnt <= bcnt - 1;
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_log(input int i, input logic [5:0] c, input logic [7:0] d);
    chk($sformatf("log%0d", i), 64'(log_q[i]), 64'({c, d}));
  endtask

  task automatic wait_done(input int max, output int cyc);
    cyc = 0;
    while (done !== 1'b1 && cyc < max) begin tick(); cyc++; end
    chk("done_seen", 64'(done), 64'd1);
  endtask

  task automatic pulse_rd(input logic [8*AB-1:0] a);
    rd_addr = a; rd_req = 1'b1;
    tick();
    rd_req = 1'b0;
  endtask

  task automatic run_stream(input int pct, input int max);
    int k = 0;
    logic pend = 1'b0;
    logic [7:0] pd = 8'h00;
    got_q.delete(); stall_err = 0;
    while (done !== 1'b1 && k < max) begin
      if (pend && (rd_valid !== 1'b1 || rd_data !== pd)) stall_err++;
      rd_ready = ($urandom_range(0, 99) < pct);
      if (rd_valid === 1'b1 && rd_ready) got_q.push_back(rd_data);
      pend = (rd_valid === 1'b1) && !rd_ready;
      pd = rd_data;
      tick(); k++;
    end
    rd_ready = 1'b0;
    chk("stream_done", 64'(done), 64'd1);
  endtask

  task automatic chk_init_log();
    chk("init_log_len", 64'(log_q.size()), 64'd9);
    chk_log(0, 6'h01, 8'h00); chk_log(1, 6'h0E, 8'h00);
    chk_log(2, 6'h04, 8'h00); chk_log(3, 6'h06, 8'h00);
    for (int i = 4; i < 9; i++) chk_log(i, 6'h13, 8'h00);
  endtask

  task automatic chk_read_log(input logic [8*AB-1:0] a);
    int gets = 0;
    chk("read_log_len", 64'(log_q.size()), 64'(AB + 4 + PB));
    chk_log(0, 6'h12, 8'h00);
    for (int i = 0; i < AB; i++) chk_log(1 + i, 6'h18, a[i*8 +: 8]);
    chk_log(AB + 1, 6'h09, 8'h00);
    chk_log(AB + 2, 6'h12, 8'h00);
    for (int i = AB + 3; i < AB + 3 + PB; i++) if (log_q[i] == {6'h15, 8'h00}) gets++;
    chk("get_count", 64'(gets), 64'(PB));
    chk_log(AB + 3 + PB, 6'h0D, 8'h00);
  endtask

  task automatic chk_page();
    chk("page_len", 64'(got_q.size()), 64'(PB));
    for (int i = 0; i < PB; i++) chk($sformatf("page%0d", i), 64'(got_q[i]), 64'(8'h40 + i));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    // reset state
    repeat (3) tick();
    chk("rst_ready", 64'(ready), 0);      chk("rst_id", 64'(id_bytes), 0);
    chk("rst_status", 64'(status), 0);    chk("rst_valid", 64'(rd_valid), 0);
    chk("rst_done", 64'(done), 0);        chk("rst_err", 64'(err), 0);
    chk("rst_cmd", 64'(nif.nm_cmd), 0);   chk("rst_act", 64'(nif.nm_activate), 0);

    // automatic init after reset release
    reset = 1'b0;
    wait_done(400, n);
    chk("init_ready", 64'(ready), 1);
    chk("init_id", 64'(id_bytes), 64'h86_03_FF_E5_2C);
    chk_init_log();
    tick();
    chk("done_one_cycle", 64'(done), 0);

    // read 1, consumer always ready
    log_q.delete();
    pulse_rd(40'h00_00_01_00_00);
    chk("ready_drops", 64'(ready), 0);
    run_stream(100, 2000);
    chk("status", 64'(status), 64'hE0);
    chk("read_ready", 64'(ready), 1);
    chk_read_log(40'h00_00_01_00_00);
    chk_page();

    // read 2, 30% ready duty, plus a rd_req while busy that must be dropped
    log_q.delete();
    pulse_rd(40'h12_34_56_78_9A);
    pulse_rd(40'hFF_FF_FF_FF_FF);
    run_stream(30, 5000);
    chk("stall_stable", 64'(stall_err), 0);
    chk_read_log(40'h12_34_56_78_9A);
    chk_page();

    // watchdog: model hangs on 09
    hang_read = 1'b1; log_q.delete();
    pulse_rd(40'h0);
    nf = 0;
    while (!(nif.nm_activate === 1'b1 && nif.nm_cmd === 6'h09) && nf < 300) begin tick(); nf++; end
    chk("read_cmd_seen", 64'(nf < 300), 1);
    chk("err_before_to", 64'(err), 0);
    wait_done(300, n);
    chk("to_cycles", 64'(n), 64'd65);
    chk("to_err", 64'(err), 1);
    chk("to_ready", 64'(ready), 1);
    hang_read = 1'b0;
    repeat (6) tick();
    chk("err_sticky", 64'(err), 1);

    // init_req and rd_req together: init wins, err clears
    log_q.delete();
    rd_addr = 40'h0; init_req = 1'b1; rd_req = 1'b1;
    tick();
    init_req = 1'b0; rd_req = 1'b0;
    wait_done(400, n);
    chk_init_log();
    chk("reinit_err", 64'(err), 0);
    chk("reinit_ready", 64'(ready), 1);

    // reset while byte 5 is stalled in the stream
    log_q.delete();
    pulse_rd(40'h0);
    rd_ready = 1'b1; cnt = 0; n = 0;
    while (cnt < 5 && n < 500) begin if (rd_valid === 1'b1) cnt++; tick(); n++; end
    rd_ready = 1'b0;
    n = 0;
    while (rd_valid !== 1'b1 && n < 100) begin tick(); n++; end
    chk("byte5_data", 64'(rd_data), 64'h45);
    repeat (3) tick();
    chk("byte5_held", 64'({rd_valid, rd_data}), 64'h145);
    #2 reset = 1'b1;
    #1;
    chk("mid_valid", 64'(rd_valid), 0);   chk("mid_act", 64'(nif.nm_activate), 0);
    chk("mid_ready", 64'(ready), 0);      chk("mid_cmd", 64'(nif.nm_cmd), 0);
    chk("mid_status", 64'(status), 0);    chk("mid_id", 64'(id_bytes), 0);
    tick();
    log_q.delete();
    reset = 1'b0;
    wait_done(400, n);
    chk_init_log();
    chk("post_rst_id", 64'(id_bytes), 64'h86_03_FF_E5_2C);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
